// File: rtl/gcd_pkg.sv
`default_nettype none
// ============================================================================
// Module : gcd_pkg
// Desc   : Shared widths, ALU select codes and select decoding for the GCD datapath
// Rev    : 1.0
// ============================================================================
package gcd_pkg;

    localparam int unsigned GCD_W  = 8;
    localparam int unsigned ITER_W = 16;

    localparam logic [ITER_W-1:0] ITER_MAX = 16'hFFFF;

    localparam logic [3:0] S_EQ  = 4'b1111;
    localparam logic [3:0] S_LT  = 4'b1110;
    localparam logic [3:0] S_SUB = 4'b0010;
    localparam logic [3:0] S_NOP = 4'b0000;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_EQ  = 2'd1,
        OP_LT  = 2'd2,
        OP_SUB = 2'd3
    } alu_op_e;

    // Any code outside the three defined ones behaves as a no-op.
    function automatic alu_op_e decode_op(input logic [3:0] s);
        alu_op_e op;
        case (s)
            S_EQ:    op = OP_EQ;
            S_LT:    op = OP_LT;
            S_SUB:   op = OP_SUB;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage : gcd_pkg
`default_nettype wire

// File: rtl/gcd_datapath_if.sv
`default_nettype none
// ============================================================================
// Module : gcd_datapath_if
// Desc   : Control/status bundle between the GCD control FSM and the datapath
// Rev    : 1.0
// ============================================================================
interface gcd_datapath_if
    import gcd_pkg::*;
#(
    parameter int unsigned W = GCD_W
) ();

    logic [W-1:0]      xin;
    logic [W-1:0]      yin;
    logic              Xs;
    logic              Ys;
    logic              Xld;
    logic              Yld;
    logic              Dld;
    logic [3:0]        S;
    logic              D;
    logic [W-1:0]      gcd_out;
    logic              gcd_valid;
    logic              err;
    logic [ITER_W-1:0] iter_cnt;

    // Controller side
    modport master (
        output xin, yin, Xs, Ys, Xld, Yld, Dld, S,
        input  D, gcd_out, gcd_valid, err, iter_cnt
    );

    // Datapath side
    modport slave (
        input  xin, yin, Xs, Ys, Xld, Yld, Dld, S,
        output D, gcd_out, gcd_valid, err, iter_cnt
    );

endinterface : gcd_datapath_if
`default_nettype wire

// File: rtl/gcd_alu.sv
`default_nettype none
// ============================================================================
// Module : gcd_alu
// Desc   : Combinational compare / subtract unit feeding the GCD registers
// Rev    : 1.0
// ============================================================================
module gcd_alu
    import gcd_pkg::*;
#(
    parameter int unsigned W = GCD_W
) (
    input  wire logic [W-1:0] x_i,
    input  wire logic [W-1:0] y_i,
    input  wire logic [3:0]   s_i,
    input  wire logic         ys_i,
    output logic      [W-1:0] alu_o,
    output logic              d_o
);

    alu_op_e w_op;

    assign w_op = decode_op(s_i);

    always_comb begin
        alu_o = '0;
        d_o   = 1'b0;
        case (w_op)
            // A zero operand forces "equal" so the controller heads to done.
            OP_EQ:   d_o = (x_i != y_i) && (x_i != '0) && (y_i != '0);
            OP_LT:   d_o = (x_i < y_i);
            OP_SUB:  alu_o = ys_i ? (y_i - x_i) : (x_i - y_i);
            default: begin
                alu_o = '0;
                d_o   = 1'b0;
            end
        endcase
    end

endmodule : gcd_alu
`default_nettype wire

// File: rtl/gcd_datapath.sv
`default_nettype none
// ============================================================================
// Module : gcd_datapath
// Desc   : Subtractive-GCD operand, result and status registers around gcd_alu
// Rev    : 1.0
// ============================================================================
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int unsigned W = GCD_W
) (
    input  wire logic     clk,
    input  wire logic     rst,
    gcd_datapath_if.slave dp
);

    logic [W-1:0]      x_q,     x_d;
    logic [W-1:0]      y_q,     y_d;
    logic [W-1:0]      out_q,   out_d;
    logic              valid_q, valid_d;
    logic              err_q,   err_d;
    logic [ITER_W-1:0] iter_q,  iter_d;

    alu_op_e      w_op;
    logic [W-1:0] w_alu;
    logic         w_d;
    logic         w_fresh;
    logic         w_dual;
    logic         w_alu_ys;
    logic         w_sub_step;
    logic         w_zero_eq;

    assign w_op       = decode_op(dp.S);
    assign w_fresh    = dp.Xld & ~dp.Xs;
    assign w_dual     = dp.Xs & dp.Ys & dp.Xld & dp.Yld;
    // Both registers reloading from the ALU is illegal; both then take X - Y.
    assign w_alu_ys   = dp.Ys & ~w_dual;
    assign w_sub_step = (w_op == OP_SUB) && (dp.Xld || dp.Yld);
    assign w_zero_eq  = (w_op == OP_EQ) && ((x_q == '0) || (y_q == '0));

    gcd_alu #(
        .W (W)
    ) u_alu (
        .x_i   (x_q),
        .y_i   (y_q),
        .s_i   (dp.S),
        .ys_i  (w_alu_ys),
        .alu_o (w_alu),
        .d_o   (w_d)
    );

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        out_d   = out_q;
        valid_d = valid_q;
        err_d   = err_q;
        iter_d  = iter_q;

        if (dp.Xld) begin
            x_d = dp.Xs ? w_alu : dp.xin;
        end
        if (dp.Yld) begin
            y_d = dp.Ys ? w_alu : dp.yin;
        end
        if (dp.Dld) begin
            out_d   = x_q;
            valid_d = 1'b1;
        end

        // A fresh job owns the status; it wins over a same-cycle Dld.
        if (w_fresh) begin
            valid_d = 1'b0;
            iter_d  = '0;
            err_d   = 1'b0;
        end else begin
            if (w_sub_step && (iter_q != ITER_MAX)) begin
                iter_d = iter_q + 16'd1;
            end
            if (w_dual || w_zero_eq) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            iter_q  <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            iter_q  <= iter_d;
        end
    end

    assign dp.D         = w_d;
    assign dp.gcd_out   = out_q;
    assign dp.gcd_valid = valid_q;
    assign dp.err       = err_q;
    assign dp.iter_cnt  = iter_q;

endmodule : gcd_datapath
`default_nettype wire

// File: tb/tb_gcd_datapath.sv
`default_nettype none
// ============================================================================
// Module : tb_gcd_datapath
// Desc   : Directed GCD jobs against a cycle-level reference model
// Rev    : 1.0
// ============================================================================
module tb_gcd_datapath;
    import gcd_pkg::*;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    gcd_datapath_if #(.W(W)) dp ();

    gcd_datapath #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .dp  (dp)
    );

    // Reference state: what the datapath must hold after each edge.
    logic [W-1:0] mX, mY, mOut;
    logic         mValid, mErr;
    logic [15:0]  mIter;

    function automatic logic model_d(input logic [3:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
        if (s == S_EQ)  return (x != y) && (x != 0) && (y != 0);
        if (s == S_LT)  return x < y;
        return 1'b0;
    endfunction

    always @(posedge clk) begin : model
        logic [W-1:0] alu, nx, ny;
        logic         both;
        if (rst) begin
            mX <= '0; mY <= '0; mOut <= '0;
            mValid <= 1'b0; mErr <= 1'b0; mIter <= '0;
        end else begin
            both = dp.Xs && dp.Ys && dp.Xld && dp.Yld;
            alu  = '0;
            if (dp.S == S_SUB)
                alu = (dp.Ys && !both) ? W'(mY - mX) : W'(mX - mY);
            nx = dp.Xld ? (dp.Xs ? alu : dp.xin) : mX;
            ny = dp.Yld ? (dp.Ys ? alu : dp.yin) : mY;
            if (dp.Dld) begin
                mOut   <= mX;
                mValid <= 1'b1;
            end
            if (dp.Xld && !dp.Xs) begin
                mValid <= 1'b0;
                mIter  <= '0;
                mErr   <= 1'b0;
            end else begin
                if (dp.S == S_SUB && (dp.Xld || dp.Yld) && mIter != 16'hFFFF)
                    mIter <= mIter + 16'd1;
                if (both || (dp.S == S_EQ && (mX == 0 || mY == 0)))
                    mErr <= 1'b1;
            end
            mX <= nx;
            mY <= ny;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_gcd_out",   dp.gcd_out,   mOut);
            check("cyc_gcd_valid", dp.gcd_valid, mValid);
            check("cyc_err",       dp.err,       mErr);
            check("cyc_iter_cnt",  dp.iter_cnt,  mIter);
            check("cyc_D",         dp.D,         model_d(dp.S, mX, mY));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dp.Xs = 1'b0; dp.Ys = 1'b0;
        dp.Xld = 1'b0; dp.Yld = 1'b0; dp.Dld = 1'b0;
        dp.S = S_NOP;
    endtask

    task automatic load(input logic [W-1:0] x, input logic [W-1:0] y);
        idle();
        dp.xin = x; dp.yin = y;
        dp.Xld = 1'b1; dp.Yld = 1'b1;
        cyc();
        idle();
    endtask

    // Plays the controller: equal test, order test, subtract, until done.
    task automatic run_fsm();
        bit done = 1'b0;
        bit lt;
        for (int n = 0; n < 600 && !done; n++) begin
            idle();
            dp.S = S_EQ;
            @(negedge clk);
            if (dp.D !== 1'b1) begin
                cyc();
                idle();
                dp.Dld = 1'b1;
                cyc();
                done = 1'b1;
            end else begin
                cyc();
                dp.S = S_LT;
                @(negedge clk);
                lt = dp.D;
                cyc();
                dp.S = S_SUB;
                if (lt) begin dp.Ys = 1'b1; dp.Yld = 1'b1; end
                else    begin dp.Xs = 1'b1; dp.Xld = 1'b1; end
                cyc();
            end
        end
        idle();
        if (!done) begin
            total++;
            bad++;
            $display("FAIL fsm_timeout: got no done, required done within 600 rounds");
        end
    endtask

    task automatic check_job(input string name, input logic [W-1:0] out, input logic valid,
                             input logic [15:0] iter, input logic e);
        check({name, "_out"},   dp.gcd_out,   out);
        check({name, "_valid"}, dp.gcd_valid, valid);
        check({name, "_iter"},  dp.iter_cnt,  iter);
        check({name, "_err"},   dp.err,       e);
        check({name, "_mdl"},   {mOut, mValid, mIter, mErr}, {out, valid, iter, e});
    endtask

    initial begin
        idle();
        dp.xin = '0; dp.yin = '0;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        chk_en = 1'b1;
        check_job("reset", 8'd0, 1'b0, 16'd0, 1'b0);

        load(8'd12, 8'd18);
        run_fsm();
        check_job("g12_18", 8'd6, 1'b1, 16'd2, 1'b0);

        cyc(); cyc();
        check_job("hold", 8'd6, 1'b1, 16'd2, 1'b0);

        // Done capture together with a fresh load keeps the old X.
        dp.xin = 8'd40; dp.yin = 8'd15;
        dp.Xld = 1'b1; dp.Yld = 1'b1; dp.Dld = 1'b1;
        cyc();
        idle();
        check_job("dld_fresh", 8'd6, 1'b0, 16'd0, 1'b0);
        run_fsm();
        check_job("g40_15", 8'd5, 1'b1, 16'd4, 1'b0);

        load(8'd7, 8'd7);
        dp.S = S_EQ;
        @(negedge clk);
        check("eq77_D", dp.D, 1'b0);
        cyc();
        run_fsm();
        check_job("g7_7", 8'd7, 1'b1, 16'd0, 1'b0);

        load(8'd1, 8'd255);
        run_fsm();
        check_job("g1_255", 8'd1, 1'b1, 16'd254, 1'b0);

        load(8'd0, 8'd9);
        run_fsm();
        check_job("g0_9", 8'd0, 1'b1, 16'd0, 1'b1);

        // Abandon a job part way through.
        load(8'd12, 8'd18);
        dp.S = S_SUB; dp.Ys = 1'b1; dp.Yld = 1'b1;
        cyc();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_job("midrst", 8'd0, 1'b0, 16'd0, 1'b0);
        load(8'd9, 8'd6);
        run_fsm();
        check_job("g9_6", 8'd3, 1'b1, 16'd2, 1'b0);

        // Both registers reloading from the ALU at once.
        load(8'd5, 8'd3);
        dp.S = S_SUB; dp.Xs = 1'b1; dp.Ys = 1'b1; dp.Xld = 1'b1; dp.Yld = 1'b1;
        cyc();
        idle();
        check("dual_err",  dp.err,      1'b1);
        check("dual_iter", dp.iter_cnt, 16'd1);
        dp.S = S_EQ;
        @(negedge clk);
        check("dual_eq_D", dp.D, 1'b0);
        cyc();
        idle();
        dp.Dld = 1'b1;
        cyc();
        idle();
        check_job("dual", 8'd2, 1'b1, 16'd1, 1'b1);

        // Undefined select: ALU yields 0, X reloads to 0.
        dp.S = 4'b0101; dp.Xs = 1'b1; dp.Xld = 1'b1;
        cyc();
        idle();
        dp.S = S_LT;
        @(negedge clk);
        check("nop_lt_D", dp.D, 1'b1);
        cyc();
        idle();
        check("nop_iter", dp.iter_cnt, 16'd1);

        load(8'd4, 8'd4);
        check("fresh_err_clr", dp.err, 1'b0);
        run_fsm();
        check_job("g4_4", 8'd4, 1'b1, 16'd0, 1'b0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_gcd_datapath
`default_nettype wire
